// File: rtl/gb_cpu_bus_responder.sv
// CPU bus responder: decodes Z80-style strobes, stalls the CPU with WAIT_n
// and turns memory cycles into single-beat req/ack transactions on a slower
// backing-memory port. Holds one posted write with read-after-write
// forwarding and answers interrupt-acknowledge cycles with a vector byte.
module gb_cpu_bus_responder #(
  parameter logic [7:0] RD_IDLE_DATA = 8'hFF
) (
  input  logic        CLK_n,
  input  logic        RESET_n,
  input  logic [15:0] A,
  input  logic [7:0]  DO,
  input  logic        MREQ_n,
  input  logic        IORQ_n,
  input  logic        RD_n,
  input  logic        WR_n,
  input  logic        M1_n,
  output logic [7:0]  DI,
  output logic        WAIT_n,
  input  logic [7:0]  irq_vector,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {WB_EMPTY, WB_FILL, WB_PEND, WB_ISSUE} wb_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAITWB, R_REQ, R_DONE} rd_state_t;

  wb_state_t   wb_st, wb_nxt;
  rd_state_t   rd_st, rd_nxt;
  logic [15:0] wb_addr;
  logic [7:0]  wb_data;
  logic [7:0]  rd_data;

  logic rd_act, wr_act, inta;
  logic wb_full, fwd_hit, write_stall, ack;
  logic wb_load, wb_issue, rd_issue, rd_fwd;

  // M1_n is not needed: an IORQ with no RD/WR already identifies INTA.
  logic unused_m1;
  assign unused_m1 = M1_n;

  assign rd_act      = !MREQ_n & !RD_n;
  assign wr_act      = !MREQ_n & !WR_n;
  assign inta        = !IORQ_n & MREQ_n & RD_n & WR_n;
  assign wb_full     = (wb_st == WB_PEND) | (wb_st == WB_ISSUE);
  assign fwd_hit     = wb_full & (wb_addr == A);
  // A write can only be active in PEND/ISSUE if it started after the
  // buffered one closed, so it must wait for the drain.
  assign write_stall = wr_act & wb_full;
  // Acks arriving with no request outstanding are ignored.
  assign ack         = mem_ack & mem_req;

  // Write buffer next state. EMPTY captures on a level so a write that was
  // stalled behind a drain is picked up as soon as the buffer frees.
  always_comb begin
    wb_nxt   = wb_st;
    wb_load  = 1'b0;
    wb_issue = 1'b0;
    case (wb_st)
      WB_EMPTY: if (wr_act) begin
        wb_nxt  = WB_FILL;
        wb_load = 1'b1;
      end
      WB_FILL: begin
        if (wr_act) wb_load = 1'b1;
        else        wb_nxt  = WB_PEND;
      end
      WB_PEND: if (rd_st != R_REQ) begin
        wb_nxt   = WB_ISSUE;
        wb_issue = 1'b1;
      end
      WB_ISSUE: if (ack) wb_nxt = WB_EMPTY;
      default: wb_nxt = WB_EMPTY;
    endcase
  end

  // Read FSM next state. IDLE reacts to the strobe level (not only its edge)
  // so a strobe held across reset still gets served instead of hanging WAIT_n.
  always_comb begin
    rd_nxt   = rd_st;
    rd_issue = 1'b0;
    rd_fwd   = 1'b0;
    case (rd_st)
      R_IDLE: if (rd_act) begin
        if (fwd_hit) begin
          rd_nxt = R_DONE;
          rd_fwd = 1'b1;
        end else if (wb_st != WB_EMPTY) begin
          rd_nxt = R_WAITWB;
        end else begin
          rd_nxt   = R_REQ;
          rd_issue = 1'b1;
        end
      end
      R_WAITWB: if (wb_st == WB_EMPTY) begin
        rd_nxt   = R_REQ;
        rd_issue = 1'b1;
      end
      R_REQ:  if (ack)     rd_nxt = R_DONE;
      R_DONE: if (!rd_act) rd_nxt = R_IDLE;
      default: rd_nxt = R_IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge CLK_n or negedge RESET_n) begin
    if (!RESET_n) begin
      wb_st <= WB_EMPTY;
      rd_st <= R_IDLE;
    end else begin
      wb_st <= wb_nxt;
      rd_st <= rd_nxt;
    end
  end

  // Posted-write capture; last value seen while the strobe is low wins.
  always_ff @(posedge CLK_n or negedge RESET_n) begin
    if (!RESET_n) begin
      wb_addr <= '0;
      wb_data <= '0;
    end else if (wb_load) begin
      wb_addr <= A;
      wb_data <= DO;
    end
  end

  // Read data register. A forwarded hit is also latched so DI stays right
  // if the buffer drains while the CPU is still finishing the read.
  always_ff @(posedge CLK_n or negedge RESET_n) begin
    if (!RESET_n)                   rd_data <= 8'hFF;
    else if (rd_st == R_REQ && ack) rd_data <= mem_rdata;
    else if (rd_fwd)                rd_data <= wb_data;
  end

  // Backend port: one outstanding request, dropped the cycle after ack.
  always_ff @(posedge CLK_n or negedge RESET_n) begin
    if (!RESET_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (rd_issue) begin
      mem_req  <= 1'b1;
      mem_we   <= 1'b0;
      mem_addr <= A;
    end else if (wb_issue) begin
      mem_req   <= 1'b1;
      mem_we    <= 1'b1;
      mem_addr  <= wb_addr;
      mem_wdata <= wb_data;
    end else if (ack) begin
      mem_req <= 1'b0;
    end
  end

  // CPU-facing read data mux and stall.
  always_comb begin
    DI = RD_IDLE_DATA;
    if (inta)                            DI = irq_vector;
    else if (rd_act && fwd_hit)          DI = wb_data;
    else if (rd_act && rd_st == R_DONE)  DI = rd_data;
    WAIT_n = !((rd_act & !fwd_hit & (rd_st != R_DONE)) | write_stall);
  end

endmodule

// File: tb/tb_gb_cpu_bus_responder.sv
// Self-checking bench for gb_cpu_bus_responder: strobe decode vectors from a
// table, hand-written multi-cycle sequences, and a backend model that checks
// every acked transaction against an expected-transaction queue.
module tb_gb_cpu_bus_responder;

  logic        CLK_n = 1'b0;
  logic        RESET_n = 1'b0;
  logic [15:0] A = '0;
  logic [7:0]  DO = '0;
  logic        MREQ_n = 1'b1, IORQ_n = 1'b1, RD_n = 1'b1, WR_n = 1'b1, M1_n = 1'b1;
  logic [7:0]  DI;
  logic        WAIT_n;
  logic [7:0]  irq_vector = '0;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'hFF;
  logic        mem_ack = 1'b0;

  gb_cpu_bus_responder dut (
    .CLK_n(CLK_n), .RESET_n(RESET_n), .A(A), .DO(DO),
    .MREQ_n(MREQ_n), .IORQ_n(IORQ_n), .RD_n(RD_n), .WR_n(WR_n), .M1_n(M1_n),
    .DI(DI), .WAIT_n(WAIT_n), .irq_vector(irq_vector),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 CLK_n = ~CLK_n;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- backend model + scoreboard ----------------
  typedef struct { logic we; logic [15:0] addr; logic [7:0] wdata; } txn_t;
  txn_t       sb[$];
  logic [7:0] bmem [0:65535];
  int         ack_lat = 0;
  bit         ack_en  = 1'b1;
  int         cnt     = 0;

  // Acks are decided at negedge so they are stable around the next posedge.
  always @(negedge CLK_n) begin
    txn_t e;
    mem_ack = 1'b0;
    if (!RESET_n) cnt = 0;
    else if (mem_req && ack_en) begin
      if (cnt >= ack_lat) begin
        cnt       = 0;
        mem_ack   = 1'b1;
        mem_rdata = bmem[mem_addr];
        chk("sb_nonempty", 16'(sb.size() != 0), 16'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("sb_we", 16'(mem_we), 16'(e.we));
          chk("sb_addr", mem_addr, e.addr);
          if (e.we) begin
            chk("sb_wdata", 16'(mem_wdata), 16'(e.wdata));
            bmem[mem_addr] = mem_wdata;
          end
        end
      end else cnt++;
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge CLK_n); #1;
  endtask

  task automatic idle_bus();
    MREQ_n = 1'b1; IORQ_n = 1'b1; RD_n = 1'b1; WR_n = 1'b1; M1_n = 1'b1;
  endtask

  task automatic push(input logic we, input logic [15:0] addr, input logic [7:0] d);
    txn_t t;
    t.we = we; t.addr = addr; t.wdata = d;
    sb.push_back(t);
  endtask

  // Counts consecutive cycles with WAIT_n low, starting in the current cycle.
  task automatic count_wait(output int n);
    n = 0;
    while (!WAIT_n && n < 30) begin
      n++;
      tick(); #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || mem_req) && n < 40) begin
      n++;
      tick();
    end
    chk("drain_timeout", 16'(n < 40), 16'd1);
  endtask

  typedef struct {
    logic mreq, iorq, rd, wr, m1;
    logic [7:0] irq;
    logic [7:0] di;
    logic wt;
    string name;
  } vec_t;

  initial begin
    vec_t vt[6];
    int n;

    vt[0] = '{1, 1, 1, 1, 1, 8'h00, 8'hFF, 1, "idle"};
    vt[1] = '{1, 0, 1, 1, 0, 8'h48, 8'h48, 1, "inta"};
    vt[2] = '{1, 0, 1, 1, 1, 8'hA7, 8'hA7, 1, "inta_nom1"};
    vt[3] = '{1, 0, 0, 1, 1, 8'h48, 8'hFF, 1, "io_read"};
    vt[4] = '{1, 0, 1, 0, 1, 8'h48, 8'hFF, 1, "io_write"};
    vt[5] = '{0, 1, 1, 1, 1, 8'h48, 8'hFF, 1, "refresh"};

    bmem[16'hC000] = 8'h5A; bmem[16'hC020] = 8'h77; bmem[16'hC050] = 8'hE1;
    bmem[16'hC060] = 8'h12; bmem[16'hC061] = 8'h3D; bmem[16'hC080] = 8'h6B;

    // ---- reset state ----
    repeat (3) tick();
    chk("rst_mem_req", 16'(mem_req), 16'd0);
    chk("rst_mem_we", 16'(mem_we), 16'd0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_mem_wdata", 16'(mem_wdata), 16'h00);
    chk("rst_wait", 16'(WAIT_n), 16'd1);
    chk("rst_di", 16'(DI), 16'hFF);
    RESET_n = 1'b1;
    tick();

    // ---- strobe decode table ----
    for (int i = 0; i < 6; i++) begin
      tick();
      MREQ_n = vt[i].mreq; IORQ_n = vt[i].iorq; RD_n = vt[i].rd;
      WR_n = vt[i].wr; M1_n = vt[i].m1; irq_vector = vt[i].irq;
      #1;
      chk({vt[i].name, "_di"}, 16'(DI), 16'(vt[i].di));
      chk({vt[i].name, "_wait"}, 16'(WAIT_n), 16'(vt[i].wt));
      tick();
      chk({vt[i].name, "_noreq"}, 16'(mem_req), 16'd0);
      idle_bus();
    end

    // ---- read miss, ack in the third mem_req cycle ----
    ack_lat = 2;
    push(0, 16'hC000, 8'h00);
    tick();
    A = 16'hC000; MREQ_n = 1'b0; RD_n = 1'b0; #1;
    count_wait(n);
    chk("miss_wait_cycles", 16'(n), 16'd4);
    chk("miss_di", 16'(DI), 16'h5A);
    chk("miss_req_dropped", 16'(mem_req), 16'd0);
    tick(); idle_bus();

    // ---- posted write, forwarded read, backend stalled ----
    ack_en = 1'b0;
    push(1, 16'hC010, 8'h3C);
    tick();
    A = 16'hC010; DO = 8'h3C; MREQ_n = 1'b0; WR_n = 1'b0; #1;
    chk("wr_zero_wait", 16'(WAIT_n), 16'd1);
    tick();
    tick(); idle_bus(); #1;
    chk("wr_req_u0", 16'(mem_req), 16'd0);
    tick();
    A = 16'hC010; MREQ_n = 1'b0; RD_n = 1'b0; #1;
    chk("fwd_wait", 16'(WAIT_n), 16'd1);
    chk("fwd_di", 16'(DI), 16'h3C);
    chk("wr_req_u1", 16'(mem_req), 16'd0);
    tick(); #1;
    chk("wr_req_u2", 16'(mem_req), 16'd1);
    chk("wr_req_we", 16'(mem_we), 16'd1);
    chk("wr_req_addr", mem_addr, 16'hC010);
    chk("wr_req_data", 16'(mem_wdata), 16'h3C);
    chk("fwd_issue_wait", 16'(WAIT_n), 16'd1);
    chk("fwd_issue_di", 16'(DI), 16'h3C);
    tick(); idle_bus();
    ack_en = 1'b1; ack_lat = 0;
    drain();

    // ---- write then read of another address: write drains first ----
    ack_lat = 1;
    push(1, 16'hC010, 8'hA5);
    push(0, 16'hC020, 8'h00);
    tick();
    A = 16'hC010; DO = 8'hA5; MREQ_n = 1'b0; WR_n = 1'b0;
    tick(); idle_bus();
    tick();
    A = 16'hC020; MREQ_n = 1'b0; RD_n = 1'b0; #1;
    chk("rawd_stall", 16'(WAIT_n), 16'd0);
    count_wait(n);
    chk("rawd_done", 16'(WAIT_n), 16'd1);
    chk("rawd_di", 16'(DI), 16'h77);
    tick(); idle_bus();
    drain();

    // ---- back-to-back writes: second stalls behind the first ----
    ack_lat = 3;
    push(1, 16'hC030, 8'h11);
    push(1, 16'hC031, 8'h22);
    tick();
    A = 16'hC030; DO = 8'h11; MREQ_n = 1'b0; WR_n = 1'b0;
    tick(); idle_bus();
    n = 0;
    while (!mem_req && n < 10) begin n++; tick(); end
    A = 16'hC031; DO = 8'h22; MREQ_n = 1'b0; WR_n = 1'b0; #1;
    chk("b2b_stall", 16'(WAIT_n), 16'd0);
    count_wait(n);
    chk("b2b_stalled", 16'(n > 0 && n < 30), 16'd1);
    tick(); idle_bus();
    drain();

    // ---- ack coinciding with a new read while the write is in ISSUE ----
    ack_lat = 0;
    push(1, 16'hC040, 8'h99);
    push(0, 16'hC050, 8'h00);
    tick();
    A = 16'hC040; DO = 8'h99; MREQ_n = 1'b0; WR_n = 1'b0;
    tick(); idle_bus();
    tick();
    tick();
    chk("coin_issue", 16'(mem_req), 16'd1);
    A = 16'hC050; MREQ_n = 1'b0; RD_n = 1'b0; #1;
    count_wait(n);
    chk("coin_wait_cycles", 16'(n), 16'd3);
    chk("coin_di", 16'(DI), 16'hE1);
    tick(); idle_bus();
    drain();

    // ---- CPU aborts a read before ack; FSM must still recover ----
    ack_lat = 2;
    push(0, 16'hC060, 8'h00);
    tick();
    A = 16'hC060; MREQ_n = 1'b0; RD_n = 1'b0;
    tick();
    tick(); idle_bus();
    n = 0;
    while (mem_req && n < 10) begin n++; tick(); end
    tick(); #1;
    chk("abort_wait", 16'(WAIT_n), 16'd1);
    chk("abort_di", 16'(DI), 16'hFF);
    ack_lat = 0;
    push(0, 16'hC061, 8'h00);
    A = 16'hC061; MREQ_n = 1'b0; RD_n = 1'b0; #1;
    count_wait(n);
    chk("abort_next_wait", 16'(n), 16'd2);
    chk("abort_next_di", 16'(DI), 16'h3D);
    tick(); idle_bus();
    drain();

    // ---- reset while a read request is outstanding ----
    ack_en = 1'b0;
    push(0, 16'hC070, 8'h00);
    tick();
    A = 16'hC070; MREQ_n = 1'b0; RD_n = 1'b0;
    tick();
    tick();
    chk("rstmid_req_before", 16'(mem_req), 16'd1);
    RESET_n = 1'b0; idle_bus(); #1;
    chk("rstmid_req", 16'(mem_req), 16'd0);
    chk("rstmid_addr", mem_addr, 16'h0000);
    chk("rstmid_wait", 16'(WAIT_n), 16'd1);
    chk("rstmid_di", 16'(DI), 16'hFF);
    sb.delete();
    tick();
    RESET_n = 1'b1; ack_en = 1'b1; ack_lat = 0;
    tick();
    push(0, 16'hC080, 8'h00);
    A = 16'hC080; MREQ_n = 1'b0; RD_n = 1'b0; #1;
    count_wait(n);
    chk("rstmid_after_wait", 16'(n), 16'd2);
    chk("rstmid_after_di", 16'(DI), 16'h6B);
    tick(); idle_bus();
    drain();

    chk("sb_empty_end", 16'(sb.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
